// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Word-aligned and inside [base, base+size); 33-bit end avoids overflow at the top.
    function automatic logic fetch_addr_ok(input logic [31:0] pc,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
        logic [32:0] w_end;
        w_end = {1'b0, base} + {1'b0, size};
        return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < w_end);
    endfunction

endpackage

// File: rtl/ifu_buf.sv
// Fetch output buffer: holds one instruction, its PC and fault flag for decode.
module ifu_buf
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_exc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_exc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_exc;

    // Clearing leaves instr/pc in place; only the valid and fault flags drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_exc   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_exc   <= i_exc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_exc   <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_exc   = r_exc;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC register, single-outstanding imem requests, redirect squash.
// Optional fetch-address fault detection is enabled by defining FETCH_EXC_EN.
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    input  logic        i_id_ready,
    output logic        o_if_exc
);

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_pc;
    logic [31:0] w_pc_d;
    logic        r_kill;
    logic        w_kill_d;
    logic        w_load;
    logic        w_clear;
    logic [31:0] w_load_instr;
    logic        w_load_exc;
    logic        w_fault;

`ifdef FETCH_EXC_EN
    assign w_fault = !fetch_addr_ok(r_pc, IMEM_BASE, IMEM_SIZE);
`else
    logic w_cfg_unused;
    assign w_fault      = 1'b0;
    assign w_cfg_unused = ^{IMEM_BASE, IMEM_SIZE};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_kill  <= w_kill_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_kill_d     = r_kill;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_load_instr = i_imem_rdata;
        w_load_exc   = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (i_redirect_valid) begin
                    w_pc_d = i_redirect_pc;
                end else if (w_fault) begin
                    w_load       = 1'b1;
                    w_load_instr = NOP_INSTR;
                    w_load_exc   = 1'b1;
                    w_state_d    = StHold;
                end else begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (i_redirect_valid) begin
                    w_pc_d = i_redirect_pc;
                    // A response arriving now is the one being squashed; nothing left to kill.
                    if (i_imem_rvalid) begin
                        w_kill_d  = 1'b0;
                        w_state_d = StFetch;
                    end else begin
                        w_kill_d = 1'b1;
                    end
                end else if (i_imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_d  = 1'b0;
                        w_state_d = StFetch;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_d    = r_pc + 32'd4;
                        w_state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (i_redirect_valid) begin
                    w_clear   = 1'b1;
                    w_pc_d    = i_redirect_pc;
                    w_state_d = StFetch;
                end else if (i_id_ready) begin
                    w_clear   = 1'b1;
                    w_state_d = StFetch;
                end
            end
            default: w_state_d = StFetch;
        endcase
    end

    always_comb begin
        o_imem_req  = rst_n && (r_state == StFetch) && !i_redirect_valid && !w_fault;
        o_imem_addr = r_pc;
    end

    ifu_buf #(
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_instr (w_load_instr),
        .i_pc    (r_pc),
        .i_exc   (w_load_exc),
        .o_valid (o_if_valid),
        .o_instr (o_if_instr),
        .o_pc    (o_if_pc),
        .o_exc   (o_if_exc)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed cycle table plus randomized run against a stream model.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic        i_id_ready;
    logic        o_if_exc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_if_valid       (o_if_valid),
        .o_if_instr       (o_if_instr),
        .o_if_pc          (o_if_pc),
        .i_id_ready       (i_id_ready),
        .o_if_exc         (o_if_exc)
    );

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] ra;
        logic        rdy;
        logic        er;
        logic [31:0] ea;
        logic        ev;
        logic [31:0] ep;
        logic        ex;
    } vec_t;

    vec_t tab[$];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC3A5_0000;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rv,
                                input logic [31:0] ra, input logic rdy, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                                input logic ex);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.rv = rv; v.ra = ra; v.rdy = rdy;
        v.er = er; v.ea = ea; v.ev = ev; v.ep = ep; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic apply(input vec_t v, input int idx);
        i_redirect_valid = v.rd;
        i_redirect_pc    = v.rpc;
        i_imem_rvalid    = v.rv;
        i_imem_rdata     = v.rv ? memw(v.ra) : 32'hDEAD_BEEF;
        i_id_ready       = v.rdy;
        @(negedge clk);
        chk($sformatf("v%0d req", idx), o_imem_req, v.er);
        chk($sformatf("v%0d addr", idx), o_imem_addr, v.ea);
        chk($sformatf("v%0d valid", idx), o_if_valid, v.ev);
        chk($sformatf("v%0d exc", idx), o_if_exc, v.ex);
        if (v.ev) begin
            chk($sformatf("v%0d if_pc", idx), o_if_pc, v.ep);
            chk($sformatf("v%0d if_instr", idx), o_if_instr, v.ex ? 32'h0 : memw(v.ep));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'h0;
        i_imem_rvalid    = 1'b0;
        i_imem_rdata     = 32'h0;
        i_id_ready       = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    int          pend_cnt;
    int          delivered;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("reset req", o_imem_req, 1'b0);
        chk("reset valid", o_if_valid, 1'b0);
        chk("reset if_pc", o_if_pc, 32'h0000_3000);
        chk("reset if_instr", o_if_instr, 32'h0);
        chk("reset exc", o_if_exc, 1'b0);
        chk("reset addr", o_imem_addr, 32'h0000_3000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // rd rpc rv ra rdy | req addr valid pc exc
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3000, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3000, 1,   0, 32'h3000, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3004, 1, 32'h3000, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3004, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3004, 1,   0, 32'h3004, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tab.push_back(mk(0, 0, 0, 0, 0,      0, 32'h3008, 1, 32'h3004, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3008, 1, 32'h3004, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3008, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3008, 1,   0, 32'h3008, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h300C, 1, 32'h3008, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h300C, 0, 0, 0));
        // Redirect while waiting on a 4-cycle memory: stale word dropped.
        tab.push_back(mk(1, 32'h3100, 0, 0, 1,   0, 32'h300C, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3100, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3100, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h300C, 1,   0, 32'h3100, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3100, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3100, 1,   0, 32'h3100, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3104, 1, 32'h3100, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3104, 0, 0, 0));
        // Redirect together with rvalid: no kill left behind.
        tab.push_back(mk(1, 32'h3200, 1, 32'h3104, 1, 0, 32'h3104, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3200, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3200, 1,   0, 32'h3200, 0, 0, 0));
        // Redirect in HOLD with id_ready.
        tab.push_back(mk(1, 32'h3040, 0, 0, 1,   0, 32'h3204, 1, 32'h3200, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3040, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3040, 1,   0, 32'h3040, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3044, 1, 32'h3040, 0));
        // Redirect in FETCH suppresses the request.
        tab.push_back(mk(1, 32'h3080, 0, 0, 1,   0, 32'h3044, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3080, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3080, 1,   0, 32'h3080, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3084, 1, 32'h3080, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3084, 0, 0, 0));
        // Two redirects while killing: last target wins, one response dropped.
        tab.push_back(mk(1, 32'h3300, 0, 0, 1,   0, 32'h3084, 0, 0, 0));
        tab.push_back(mk(1, 32'h3310, 0, 0, 1,   0, 32'h3300, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3084, 1,   0, 32'h3310, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3310, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3310, 1,   0, 32'h3310, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3314, 1, 32'h3310, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h3314, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3314, 1,   0, 32'h3314, 0, 0, 0));
`ifndef FETCH_EXC_EN
        // PC wraps past the top of the address space.
        tab.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h3318, 1, 32'h3314, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'hFFFF_FFFC, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h0, 1, 32'hFFFF_FFFC, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          1, 32'h0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h0, 1,      0, 32'h0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h4, 1, 32'h0, 0));
`else
        // Misaligned target faults without a request and repeats until redirected.
        tab.push_back(mk(1, 32'h3002, 0, 0, 0,   0, 32'h3318, 1, 32'h3314, 0));
        tab.push_back(mk(0, 0, 0, 0, 0,          0, 32'h3002, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0,          0, 32'h3002, 1, 32'h3002, 1));
        tab.push_back(mk(0, 0, 0, 0, 0,          0, 32'h3002, 1, 32'h3002, 1));
        tab.push_back(mk(0, 0, 0, 0, 1,          0, 32'h3002, 1, 32'h3002, 1));
        tab.push_back(mk(0, 0, 0, 0, 0,          0, 32'h3002, 0, 0, 0));
        tab.push_back(mk(1, 32'h3000, 0, 0, 0,   0, 32'h3002, 1, 32'h3002, 1));
        tab.push_back(mk(0, 0, 0, 0, 0,          1, 32'h3000, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 32'h3000, 0,   0, 32'h3000, 0, 0, 0));
        // End of window is exclusive; last word is legal.
        tab.push_back(mk(1, 32'h7000, 0, 0, 0,   0, 32'h3004, 1, 32'h3000, 0));
        tab.push_back(mk(0, 0, 0, 0, 0,          0, 32'h7000, 0, 0, 0));
        tab.push_back(mk(1, 32'h6FFC, 0, 0, 0,   0, 32'h7000, 1, 32'h7000, 1));
        tab.push_back(mk(0, 0, 0, 0, 0,          1, 32'h6FFC, 0, 0, 0));
`endif
        for (int i = 0; i < tab.size(); i++) apply(tab[i], i);

        // Randomized run: fetch stream must be sequential from the latest redirect.
        idle_inputs();
        rst_n = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_pc    = 32'h0000_3000;
        pend      = 1'b0;
        pend_cnt  = 0;
        pend_addr = 32'h0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
            if (pend) begin
                if (pend_cnt == 1) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = memw(pend_addr);
                    pend          = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            i_redirect_valid = ($urandom_range(0, 7) == 0);
            i_redirect_pc    = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
            i_id_ready       = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (o_imem_req) begin
                chk("rand req addr", o_imem_addr, exp_pc);
                chk("rand single outstanding", {31'b0, pend}, 32'h0);
                chk("rand req while holding", o_if_valid, 1'b0);
                pend      = 1'b1;
                pend_addr = o_imem_addr;
                pend_cnt  = $urandom_range(1, 4);
            end
            if (o_if_valid && i_id_ready) begin
                chk("rand if_pc", o_if_pc, exp_pc);
                chk("rand if_instr", o_if_instr, memw(exp_pc));
                chk("rand if_exc", o_if_exc, 1'b0);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (i_redirect_valid) exp_pc = i_redirect_pc;
            @(posedge clk);
            #1;
        end
        chk("rand enough deliveries", (delivered > 100), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
